// File: rtl/peak_decode.sv
// RV32I decode stage: combinational decoder feeding a one-deep output register plus a
// one-deep skid buffer, so fetch can stream one instruction per cycle under backpressure.
module peak_decode (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FLUSH,
  input  logic        I_VALID,
  output logic        I_READY,
  input  logic [31:0] I_INST,
  input  logic [31:0] I_PC,
  output logic        O_VALID,
  input  logic        O_READY,
  output logic [31:0] O_PC,
  output logic [4:0]  RD_NUM,
  output logic [4:0]  RS1_NUM,
  output logic [4:0]  RS2_NUM,
  output logic [31:0] IMM,
  output logic [2:0]  FUNCT3,
  output logic        INST_IMM,
  output logic        INST_ADD,
  output logic        INST_SUB,
  output logic        INST_SHL,
  output logic        INST_SHR,
  output logic        INST_SHRA,
  output logic        INST_XOR,
  output logic        INST_OR,
  output logic        INST_AND,
  output logic        INST_BR,
  output logic        INST_LTS,
  output logic        INST_LTU,
  output logic        INST_EQ,
  output logic        INST_BR_NOT,
  output logic        INST_JAL,
  output logic        INST_JALR,
  output logic        INST_LUI,
  output logic        INST_AUIPC,
  output logic        INST_LOAD,
  output logic        INST_STORE,
  output logic        ILLEGAL
);

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [2:0]  funct3;
    logic        is_imm;
    logic        is_add;
    logic        is_sub;
    logic        is_shl;
    logic        is_shr;
    logic        is_shra;
    logic        is_xor;
    logic        is_or;
    logic        is_and;
    logic        is_br;
    logic        is_lts;
    logic        is_ltu;
    logic        is_eq;
    logic        is_br_not;
    logic        is_jal;
    logic        is_jalr;
    logic        is_lui;
    logic        is_auipc;
    logic        is_load;
    logic        is_store;
    logic        illegal;
  } dec_t;

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e      state_q, state_d;
  dec_t        out_q, out_d;
  dec_t        skid_q, skid_d;
  dec_t        dec;
  logic        ready_q, ready_d;
  logic        accept, out_fire;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u, imm_sh;
  logic        ill;

  assign opcode = I_INST[6:0];
  assign f3     = I_INST[14:12];
  assign f7     = I_INST[31:25];
  assign imm_i  = {{20{I_INST[31]}}, I_INST[31:20]};
  assign imm_s  = {{20{I_INST[31]}}, I_INST[31:25], I_INST[11:7]};
  assign imm_b  = {{19{I_INST[31]}}, I_INST[31], I_INST[7], I_INST[30:25], I_INST[11:8], 1'b0};
  assign imm_j  = {{11{I_INST[31]}}, I_INST[31], I_INST[19:12], I_INST[20], I_INST[30:21],
                   1'b0};
  assign imm_u  = {I_INST[31:12], 12'd0};
  assign imm_sh = {27'd0, I_INST[24:20]};

  always_comb begin
    dec        = '0;
    ill        = 1'b0;
    dec.pc     = I_PC;
    dec.rd     = I_INST[11:7];
    dec.rs1    = I_INST[19:15];
    dec.rs2    = I_INST[24:20];
    dec.funct3 = f3;
    if (I_INST[1:0] != 2'b11) begin
      ill = 1'b1;
    end else begin
      case (opcode)
        7'b0010011: begin
          dec.is_imm = 1'b1;
          dec.imm    = imm_i;
          case (f3)
            3'b000: dec.is_add = 1'b1;
            3'b010: dec.is_lts = 1'b1;
            3'b011: dec.is_ltu = 1'b1;
            3'b100: dec.is_xor = 1'b1;
            3'b110: dec.is_or  = 1'b1;
            3'b111: dec.is_and = 1'b1;
            3'b001: begin
              dec.imm = imm_sh;
              if (f7 == 7'b0000000) dec.is_shl = 1'b1;
              else                  ill        = 1'b1;
            end
            default: begin
              dec.imm = imm_sh;
              if (f7 == 7'b0000000)      dec.is_shr  = 1'b1;
              else if (f7 == 7'b0100000) dec.is_shra = 1'b1;
              else                       ill         = 1'b1;
            end
          endcase
        end
        7'b0110011: begin
          if (f7 == 7'b0000000) begin
            case (f3)
              3'b000:  dec.is_add = 1'b1;
              3'b001:  dec.is_shl = 1'b1;
              3'b010:  dec.is_lts = 1'b1;
              3'b011:  dec.is_ltu = 1'b1;
              3'b100:  dec.is_xor = 1'b1;
              3'b101:  dec.is_shr = 1'b1;
              3'b110:  dec.is_or  = 1'b1;
              default: dec.is_and = 1'b1;
            endcase
          end else if (f7 == 7'b0100000) begin
            case (f3)
              3'b000:  dec.is_sub  = 1'b1;
              3'b101:  dec.is_shra = 1'b1;
              default: ill         = 1'b1;
            endcase
          end else begin
            ill = 1'b1;
          end
        end
        7'b1100011: begin
          dec.is_br = 1'b1;
          dec.imm   = imm_b;
          case (f3)
            3'b000: dec.is_eq = 1'b1;
            3'b001: begin dec.is_eq  = 1'b1; dec.is_br_not = 1'b1; end
            3'b100: dec.is_lts = 1'b1;
            3'b101: begin dec.is_lts = 1'b1; dec.is_br_not = 1'b1; end
            3'b110: dec.is_ltu = 1'b1;
            3'b111: begin dec.is_ltu = 1'b1; dec.is_br_not = 1'b1; end
            default: ill = 1'b1;
          endcase
        end
        7'b1101111: begin
          dec.is_jal = 1'b1;
          dec.is_imm = 1'b1;
          dec.imm    = imm_j;
        end
        7'b1100111: begin
          dec.is_jalr = 1'b1;
          dec.is_imm  = 1'b1;
          dec.imm     = imm_i;
          if (f3 != 3'b000) ill = 1'b1;
        end
        7'b0110111: begin
          dec.is_lui = 1'b1;
          dec.imm    = imm_u;
        end
        7'b0010111: begin
          dec.is_auipc = 1'b1;
          dec.imm      = imm_u;
        end
        7'b0000011: begin
          dec.is_load = 1'b1;
          dec.is_imm  = 1'b1;
          dec.imm     = imm_i;
        end
        7'b0100011: begin
          dec.is_store = 1'b1;
          dec.is_imm   = 1'b1;
          dec.imm      = imm_s;
        end
        default: ill = 1'b1;
      endcase
    end
    // Illegal encodings keep only the pass-through fields; all strobes and IMM clear.
    if (ill) begin
      dec         = '0;
      dec.pc      = I_PC;
      dec.rd      = I_INST[11:7];
      dec.rs1     = I_INST[19:15];
      dec.rs2     = I_INST[24:20];
      dec.funct3  = f3;
      dec.illegal = 1'b1;
    end
  end

  assign accept   = I_VALID & ready_q;
  assign out_fire = (state_q != StEmpty) & O_READY;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      StEmpty: begin
        if (accept) begin
          state_d = StOne;
          out_d   = dec;
        end
      end
      StOne: begin
        if (accept && !out_fire) begin
          state_d = StTwo;
          skid_d  = dec;
        end else if (accept && out_fire) begin
          out_d = dec;
        end else if (out_fire) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        if (out_fire) begin
          state_d = StOne;
          out_d   = skid_q;
        end
      end
      default: state_d = StEmpty;
    endcase
    if (FLUSH) state_d = StEmpty;
    ready_d = (state_d != StTwo);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StEmpty;
      out_q   <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
    end
  end

  assign I_READY     = ready_q;
  assign O_VALID     = (state_q != StEmpty);
  assign O_PC        = out_q.pc;
  assign RD_NUM      = out_q.rd;
  assign RS1_NUM     = out_q.rs1;
  assign RS2_NUM     = out_q.rs2;
  assign IMM         = out_q.imm;
  assign FUNCT3      = out_q.funct3;
  assign INST_IMM    = out_q.is_imm;
  assign INST_ADD    = out_q.is_add;
  assign INST_SUB    = out_q.is_sub;
  assign INST_SHL    = out_q.is_shl;
  assign INST_SHR    = out_q.is_shr;
  assign INST_SHRA   = out_q.is_shra;
  assign INST_XOR    = out_q.is_xor;
  assign INST_OR     = out_q.is_or;
  assign INST_AND    = out_q.is_and;
  assign INST_BR     = out_q.is_br;
  assign INST_LTS    = out_q.is_lts;
  assign INST_LTU    = out_q.is_ltu;
  assign INST_EQ     = out_q.is_eq;
  assign INST_BR_NOT = out_q.is_br_not;
  assign INST_JAL    = out_q.is_jal;
  assign INST_JALR   = out_q.is_jalr;
  assign INST_LUI    = out_q.is_lui;
  assign INST_AUIPC  = out_q.is_auipc;
  assign INST_LOAD   = out_q.is_load;
  assign INST_STORE  = out_q.is_store;
  assign ILLEGAL     = out_q.illegal;

endmodule

// File: tb/tb_peak_decode.sv
// Directed bench for peak_decode: decode vectors, backpressure, flush and reset.
module tb_peak_decode;

  logic        CLK = 1'b0;
  logic        RST, FLUSH, I_VALID, I_READY, O_VALID, O_READY;
  logic [31:0] I_INST, I_PC, O_PC, IMM;
  logic [4:0]  RD_NUM, RS1_NUM, RS2_NUM;
  logic [2:0]  FUNCT3;
  logic INST_IMM, INST_ADD, INST_SUB, INST_SHL, INST_SHR, INST_SHRA, INST_XOR, INST_OR;
  logic INST_AND, INST_BR, INST_LTS, INST_LTU, INST_EQ, INST_BR_NOT, INST_JAL, INST_JALR;
  logic INST_LUI, INST_AUIPC, INST_LOAD, INST_STORE, ILLEGAL;

  // Strobe masks in the order packed into ops below.
  localparam logic [19:0] MImm = 20'h80000, MAdd = 20'h40000, MSub = 20'h20000;
  localparam logic [19:0] MShra = 20'h04000, MBr = 20'h00400, MEq = 20'h00080;
  localparam logic [19:0] MBrNot = 20'h00040, MJal = 20'h00020, MLui = 20'h00008;
  localparam logic [19:0] MStore = 20'h00001;

  logic [19:0] ops;
  assign ops = {INST_IMM, INST_ADD, INST_SUB, INST_SHL, INST_SHR, INST_SHRA, INST_XOR,
                INST_OR, INST_AND, INST_BR, INST_LTS, INST_LTU, INST_EQ, INST_BR_NOT,
                INST_JAL, INST_JALR, INST_LUI, INST_AUIPC, INST_LOAD, INST_STORE};

  int n_pass = 0;
  int n_total = 0;

  peak_decode dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .I_VALID(I_VALID), .I_READY(I_READY),
    .I_INST(I_INST), .I_PC(I_PC), .O_VALID(O_VALID), .O_READY(O_READY), .O_PC(O_PC),
    .RD_NUM(RD_NUM), .RS1_NUM(RS1_NUM), .RS2_NUM(RS2_NUM), .IMM(IMM), .FUNCT3(FUNCT3),
    .INST_IMM(INST_IMM), .INST_ADD(INST_ADD), .INST_SUB(INST_SUB), .INST_SHL(INST_SHL),
    .INST_SHR(INST_SHR), .INST_SHRA(INST_SHRA), .INST_XOR(INST_XOR), .INST_OR(INST_OR),
    .INST_AND(INST_AND), .INST_BR(INST_BR), .INST_LTS(INST_LTS), .INST_LTU(INST_LTU),
    .INST_EQ(INST_EQ), .INST_BR_NOT(INST_BR_NOT), .INST_JAL(INST_JAL),
    .INST_JALR(INST_JALR), .INST_LUI(INST_LUI), .INST_AUIPC(INST_AUIPC),
    .INST_LOAD(INST_LOAD), .INST_STORE(INST_STORE), .ILLEGAL(ILLEGAL)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance one clock; return 1 time unit after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic [31:0] inst, input logic [31:0] pc);
    I_VALID = 1'b1;
    I_INST  = inst;
    I_PC    = pc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    RST = 1'b1; FLUSH = 1'b0; I_VALID = 1'b0; I_INST = '0; I_PC = '0; O_READY = 1'b1;
    tick();
    tick();
    check("rst_ovalid", {31'd0, O_VALID}, 32'd0);
    check("rst_iready", {31'd0, I_READY}, 32'd1);
    check("rst_imm", IMM, 32'd0);
    check("rst_ops", {12'd0, ops, ILLEGAL}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    // Single ADDI
    tick();
    issue(32'h00500093, 32'h100);
    tick();
    I_VALID = 1'b0;
    check("addi_valid", {31'd0, O_VALID}, 32'd1);
    check("addi_ops", {12'd0, ops}, {12'd0, MImm | MAdd});
    check("addi_rd", {27'd0, RD_NUM}, 32'd1);
    check("addi_rs1", {27'd0, RS1_NUM}, 32'd0);
    check("addi_imm", IMM, 32'd5);
    check("addi_pc", O_PC, 32'h100);
    tick();
    check("addi_drop", {31'd0, O_VALID}, 32'd0);

    // Streamed decode vectors, one per cycle with O_READY high
    issue(32'h4030D113, 32'h104);
    tick();
    check("srai_ops", {12'd0, ops}, {12'd0, MImm | MShra});
    check("srai_imm", IMM, 32'd3);
    check("srai_rd", {27'd0, RD_NUM}, 32'd2);
    issue(32'hFE209CE3, 32'h108);
    tick();
    check("bne_ops", {12'd0, ops}, {12'd0, MBr | MEq | MBrNot});
    check("bne_imm", IMM, 32'hFFFFFFF8);
    check("bne_rs", {22'd0, RS1_NUM, RS2_NUM}, {22'd0, 5'd1, 5'd2});
    check("bne_pc", O_PC, 32'h108);
    issue(32'h0020A423, 32'h10C);
    tick();
    check("sw_ops", {12'd0, ops}, {12'd0, MImm | MStore});
    check("sw_imm", IMM, 32'd8);
    check("sw_f3", {29'd0, FUNCT3}, 32'd2);
    issue(32'h123452B7, 32'h110);
    tick();
    check("lui_ops", {12'd0, ops}, {12'd0, MLui});
    check("lui_imm", IMM, 32'h12345000);
    issue(32'h010000EF, 32'h114);
    tick();
    check("jal_ops", {12'd0, ops}, {12'd0, MImm | MJal});
    check("jal_imm", IMM, 32'd16);
    issue(32'h402081B3, 32'h118);
    tick();
    check("sub_ops", {12'd0, ops}, {12'd0, MSub});
    check("sub_imm", IMM, 32'd0);
    issue(32'hFFFFFFFF, 32'h11C);
    tick();
    check("ill1_valid", {31'd0, O_VALID}, 32'd1);
    check("ill1_flag", {31'd0, ILLEGAL}, 32'd1);
    check("ill1_ops", {12'd0, ops}, 32'd0);
    check("ill1_imm", IMM, 32'd0);
    issue(32'h02000033, 32'h120);
    tick();
    I_VALID = 1'b0;
    check("ill2_valid", {31'd0, O_VALID}, 32'd1);
    check("ill2_flag", {31'd0, ILLEGAL}, 32'd1);
    check("ill2_ops", {12'd0, ops}, 32'd0);
    tick();
    check("ill2_drain", {31'd0, O_VALID}, 32'd0);

    // Backpressure: three ADDIs with O_READY low
    O_READY = 1'b0;
    issue(32'h00100093, 32'h200);
    tick();
    check("bp_ready1", {31'd0, I_READY}, 32'd1);
    issue(32'h00200093, 32'h204);
    tick();
    check("bp_ready2", {31'd0, I_READY}, 32'd0);
    issue(32'h00300093, 32'h208);
    tick();
    check("bp_hold_imm", IMM, 32'd1);
    check("bp_hold_ready", {31'd0, I_READY}, 32'd0);
    O_READY = 1'b1;
    tick();
    check("bp_out2", IMM, 32'd2);
    check("bp_ready3", {31'd0, I_READY}, 32'd1);
    tick();
    I_VALID = 1'b0;
    check("bp_out3", IMM, 32'd3);
    check("bp_pc3", O_PC, 32'h208);
    tick();
    check("bp_empty", {31'd0, O_VALID}, 32'd0);

    // Flush with both stages full and fetch presenting a third
    O_READY = 1'b0;
    issue(32'h00700093, 32'h300);
    tick();
    issue(32'h00800093, 32'h304);
    tick();
    issue(32'h00900093, 32'h308);
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    I_VALID = 1'b0;
    check("fl_valid", {31'd0, O_VALID}, 32'd0);
    check("fl_ready", {31'd0, I_READY}, 32'd1);
    O_READY = 1'b1;
    tick();
    check("fl_gone1", {31'd0, O_VALID}, 32'd0);
    tick();
    check("fl_gone2", {31'd0, O_VALID}, 32'd0);

    // Flush drops an instruction accepted on the same edge
    O_READY = 1'b0;
    issue(32'h00A00093, 32'h400);
    tick();
    issue(32'h00B00093, 32'h404);
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    I_VALID = 1'b0;
    O_READY = 1'b1;
    check("fl1_valid", {31'd0, O_VALID}, 32'd0);
    tick();
    check("fl1_gone", {31'd0, O_VALID}, 32'd0);

    // Asynchronous reset mid-stream
    O_READY = 1'b0;
    issue(32'h00C00093, 32'h500);
    tick();
    issue(32'h00D00093, 32'h504);
    tick();
    I_VALID = 1'b0;
    check("mid_full", {31'd0, O_VALID}, 32'd1);
    #2;
    RST = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, O_VALID}, 32'd0);
    check("mid_rst_ready", {31'd0, I_READY}, 32'd1);
    check("mid_rst_imm", IMM, 32'd0);
    #2;
    RST = 1'b0;
    O_READY = 1'b1;
    tick();
    check("mid_after", {31'd0, O_VALID}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/peak_decode.md
Name: peak_decode

Overview:
- Instruction decode stage for the peak core. Accepts a 32-bit RV32I instruction word and its PC from fetch over a valid/ready handshake.
- Produces the registered one-hot operation strobes, immediate and register indices that drive the execute-stage ALU.
- Contains a one-deep output register plus a one-deep skid buffer, so it sustains one instruction per cycle under downstream backpressure.
- FLUSH discards in-flight instructions on branch redirect.

Parameters:
- None. Data width is fixed at 32; the ISA is RV32I without M, FENCE or SYSTEM.

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RST  in  1  reset; asynchronous assert, active-high
- FLUSH  in  1  synchronous clear of all buffered instructions
- I_VALID  in  1  fetch presents an instruction
- I_READY  out  1  decode can accept; registered
- I_INST  in  32  instruction word
- I_PC  in  32  instruction address
- O_VALID  out  1  decoded instruction valid
- O_READY  in  1  execute accepts
- O_PC  out  32  PC of the decoded instruction
- RD_NUM, RS1_NUM, RS2_NUM  out  5 each  taken from inst[11:7], [19:15], [24:20]
- IMM  out  32  decoded immediate
- FUNCT3  out  3  inst[14:12], used by load/store size
- INST_IMM, INST_ADD, INST_SUB, INST_SHL, INST_SHR, INST_SHRA, INST_XOR, INST_OR, INST_AND, INST_BR, INST_LTS, INST_LTU, INST_EQ, INST_BR_NOT, INST_JAL, INST_JALR, INST_LUI, INST_AUIPC, INST_LOAD, INST_STORE  out  1 each  operation strobes
- ILLEGAL  out  1  unsupported encoding

Behaviour:
- **Reset.** While RST is high: O_VALID=0, all INST_* and ILLEGAL=0, IMM/O_PC/FUNCT3/*_NUM=0, skid buffer empty, I_READY=1.
- **Handshakes.** Input transfer when I_VALID & I_READY; output transfer when O_VALID & O_READY. Latency is 1 cycle from input transfer to O_VALID.
- **Buffer states.**
  - EMPTY: O_VALID=0.
  - ONE: output register valid, skid empty.
  - TWO: both valid.
- **Transitions.**
  - EMPTY + accept -> ONE.
  - ONE + accept & !out -> TWO, and I_READY goes 0 on the same edge.
  - ONE + accept & out -> ONE, output register reloaded.
  - ONE + out & !accept -> EMPTY.
  - TWO + out -> ONE: skid moves to the output register and I_READY returns to 1.
  - TWO never accepts, because I_READY=0.
- **Ordering.** Program order is always preserved. Output fields are held stable while O_VALID & !O_READY.
- **Decoder.** Decoding is combinational on I_INST. Decoded fields are stored in the skid/output registers; the buffers do not hold raw instruction words.
- **OP-IMM (0010011).**
  - Always sets INST_IMM; IMM is the I-type immediate, sign-extended.
  - funct3 000 ADD, 010 LTS, 011 LTU, 100 XOR, 110 OR, 111 AND.
  - 001 SHL requires funct7=0000000.
  - 101 decodes SHR when funct7=0000000 and SHRA when funct7=0100000.
  - Shift IMM = {27'd0, inst[24:20]}.
  - Any other funct7 on a shift is ILLEGAL.
- **OP (0110011).**
  - funct7=0000000: 000 ADD, 001 SHL, 010 LTS, 011 LTU, 100 XOR, 101 SHR, 110 OR, 111 AND.
  - funct7=0100000: 000 SUB, 101 SHRA.
  - All other combinations are ILLEGAL.
  - IMM=0.
- **BRANCH (1100011).**
  - Sets INST_BR; IMM is the B-type immediate, sign-extended.
  - funct3 000 EQ, 001 EQ+BR_NOT, 100 LTS, 101 LTS+BR_NOT, 110 LTU, 111 LTU+BR_NOT.
  - funct3 010 and 011 are ILLEGAL.
- **JAL (1101111):** INST_JAL + INST_IMM, J-type immediate.
- **JALR (1100111):** requires funct3=000, else ILLEGAL. Sets INST_JALR + INST_IMM, I-type immediate.
- **LUI (0110111) / AUIPC (0010111):** INST_LUI or INST_AUIPC; IMM = {inst[31:12], 12'd0}.
- **LOAD (0000011):** INST_LOAD + INST_IMM, I-type immediate.
- **STORE (0100011):** INST_STORE + INST_IMM, S-type immediate.
- **ILLEGAL.** Any other opcode, or inst[1:0]≠11, gives ILLEGAL=1 with all INST_*=0 and IMM=0. The instruction is still passed down with O_VALID=1.
- **Strobe exclusivity.** At most one of ADD/SUB/SHL/SHR/SHRA/XOR/OR/AND/EQ/LTS/LTU is set per instruction.
- **FLUSH.**
  - On the edge with FLUSH=1, the output and skid valids clear and I_READY=1.
  - Any input transferred in that same cycle is dropped.
  - Any output transfer in that same cycle is still considered consumed.
  - FLUSH has priority over all transitions.
- **Reset mid-operation.** Immediately empties both stages, with no pending output.

Test Plan:
- Single instruction: 0x00500093 (addi x1,x0,5), PC 0x100, O_READY=1 -> next cycle O_VALID=1, INST_ADD=1, INST_IMM=1, RD_NUM=1, RS1_NUM=0, IMM=5, O_PC=0x100; O_VALID=0 the following cycle.
- Shift immediate: 0x4030D113 (srai x2,x1,3) -> INST_SHRA=1, INST_IMM=1, IMM=0x00000003, RD_NUM=2.
- Negative branch: 0xFE209CE3 (bne x1,x2,-8) -> INST_BR=1, INST_EQ=1, INST_BR_NOT=1, IMM=0xFFFFFFF8, RS1_NUM=1, RS2_NUM=2, RSLT-path strobes otherwise 0.
- Backpressure: O_READY=0, three back-to-back ADDIs with IMM 1, 2, 3 -> I_READY drops after the second is accepted and the third is held by upstream. Raise O_READY -> outputs IMM 1, 2, 3 in order on consecutive cycles, with no loss or duplication.
- Flush: both stages full plus a new I_VALID, FLUSH=1 for one cycle -> next cycle O_VALID=0 and I_READY=1, and none of the three instructions ever appears.
- Illegal encodings: 0xFFFFFFFF, and 0x02000033 (funct7=0000001 OP) -> O_VALID=1, ILLEGAL=1, every INST_*=0, IMM=0. Assert RST mid-stream -> O_VALID=0 immediately.
